pipe_stage_skid: RTL and testbench

- Generic, parametrised inter-stage pipeline register with a valid/ready handshake and a synchronous flush.
- Successor to the fixed-field stage registers (EX/MEM, MEM/WB); it carries an opaque payload, and each stage instance packs its own fields.
- Adds backpressure (stall) and flush, which the current stage registers lack.
- Optional 2-entry skid buffer gives a registered s_ready at full throughput.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-stage payload widths for pipeline stage registers
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   // MEM/WB payload: two 32-bit operands, result, rd index, wb select, reg write enable
   localparam int MEMWB_PAYLOAD_W = 2*32 + 32 + 5 + 2 + 1;

endpackage

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - parametrised valid/ready pipeline register with flush
// and optional 2-entry skid buffer (SKID=1) or single entry (SKID=0)
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    SKID       = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
);

   logic [DATA_WIDTH-1:0] data_q;
   logic                  stall_q;

   assign m_data = data_q;

   generate
      if (SKID != 0) begin : g_skid
         skid_state_e           state_q, state_d;
         logic [DATA_WIDTH-1:0] data_d;
         logic [DATA_WIDTH-1:0] skid_q, skid_d;

         // s_ready decodes straight from the state register, no path from m_ready
         assign s_ready = !rst && (state_q != ST_FULL);
         assign m_valid = (state_q != ST_EMPTY);

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               state_q <= ST_EMPTY;
               data_q  <= RESET_DATA;
               skid_q  <= '0;
            end else begin
               state_q <= state_d;
               data_q  <= data_d;
               skid_q  <= skid_d;
            end
         end

         always_comb begin
            state_d = state_q;
            data_d  = data_q;
            skid_d  = skid_q;
            case (state_q)
               ST_EMPTY: begin
                  if (s_valid) begin
                     data_d  = s_data;
                     state_d = ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  if (s_valid && m_ready) begin
                     data_d = s_data;
                  end else if (s_valid) begin
                     skid_d  = s_data;
                     state_d = ST_FULL;
                  end else if (m_ready) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (m_ready) begin
                     data_d  = skid_q;
                     state_d = ST_BUSY;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end

         always @(posedge clk) begin
            if (!rst && state_q == ST_FULL) begin
               assert (m_valid);
            end
         end
      end else begin : g_noskid
         logic valid_q;

         assign s_ready = !rst && (!valid_q || m_ready);
         assign m_valid = valid_q;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               valid_q <= 1'b0;
               data_q  <= RESET_DATA;
            end else if (s_valid && s_ready) begin
               valid_q <= 1'b1;
               data_q  <= s_data;
            end else if (m_ready) begin
               valid_q <= 1'b0;
            end
         end
      end
   endgenerate

   // Remembers an offered-but-refused request so its withdrawal can be flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= s_valid && !s_ready && !flush;
      end
   end

   always @(posedge clk) begin
      if (!rst && !flush && stall_q) begin
         assert (s_valid);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and randomised bench for pipe_stage_skid,
// index 0 is the SKID=0 instance, index 1 the SKID=1 instance
module tb_pipe_stage_skid;

   localparam logic [31:0] RST0 = 32'h5A5A_0000;
   localparam logic [31:0] RST1 = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  s_valid;
   logic [1:0]  s_ready;
   logic [1:0]  m_valid;
   logic [1:0]  m_ready;
   logic [31:0] s_data [2];
   logic [31:0] m_data [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_WIDTH(32), .SKID(0), .RESET_DATA(RST0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0])
   );

   pipe_stage_skid #(.DATA_WIDTH(32), .SKID(1), .RESET_DATA(RST1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; m_ready = 2'b00; s_valid = 2'b11;
      s_data[0] = 32'hDEAD_BEEF; s_data[1] = 32'hDEAD_BEEF;
      #1;
      checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL reset_s_ready_pre got %b exp 00", s_ready); end
      tick();
      checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL reset_s_ready got %b exp 00", s_ready); end
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL reset_m_valid got %b exp 00", m_valid); end
      tick();
      rst = 1'b0; s_valid = 2'b00;
      #1;
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL post_reset_m_valid got %b exp 00", m_valid); end
      checks++; if (s_ready !== 2'b11) begin errors++; $display("FAIL post_reset_s_ready got %b exp 11", s_ready); end
      checks++; if (m_data[0] !== RST0) begin errors++; $display("FAIL post_reset_m_data0 got %h exp %h", m_data[0], RST0); end
      checks++; if (m_data[1] !== RST1) begin errors++; $display("FAIL post_reset_m_data1 got %h exp %h", m_data[1], RST1); end
   endtask

   task automatic test_streaming();
      m_ready = 2'b11;
      for (int i = 1; i <= 3; i++) begin
         s_valid = 2'b11; s_data[0] = i; s_data[1] = i;
         #1;
         checks++; if (s_ready !== 2'b11) begin errors++; $display("FAIL stream_s_ready i=%0d got %b exp 11", i, s_ready); end
         tick();
         checks++; if (m_valid !== 2'b11) begin errors++; $display("FAIL stream_m_valid i=%0d got %b exp 11", i, m_valid); end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (m_data[k] !== 32'(i)) begin errors++; $display("FAIL stream_m_data k=%0d got %h exp %h", k, m_data[k], 32'(i)); end
         end
      end
      s_valid = 2'b00;
      tick();
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL stream_drain got %b exp 00", m_valid); end
   endtask

   task automatic test_backpressure_skid();
      m_ready = 2'b00; s_valid = 2'b10; s_data[1] = 32'hA;
      #1;
      checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL bp1_ready_a got %b exp 1", s_ready[1]); end
      tick();
      s_data[1] = 32'hB;
      #1;
      checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL bp1_ready_b got %b exp 1", s_ready[1]); end
      tick();
      s_valid = 2'b00;
      #1;
      checks++; if (s_ready[1] !== 1'b0) begin errors++; $display("FAIL bp1_full_ready got %b exp 0", s_ready[1]); end
      checks++; if (m_valid[1] !== 1'b1) begin errors++; $display("FAIL bp1_full_valid got %b exp 1", m_valid[1]); end
      checks++; if (m_data[1] !== 32'hA) begin errors++; $display("FAIL bp1_full_data got %h exp a", m_data[1]); end
      tick();
      checks++; if (m_data[1] !== 32'hA) begin errors++; $display("FAIL bp1_hold_data got %h exp a", m_data[1]); end
      m_ready = 2'b10;
      tick();
      checks++; if (m_data[1] !== 32'hB) begin errors++; $display("FAIL bp1_drain_b got %h exp b", m_data[1]); end
      checks++; if (s_ready[1] !== 1'b1) begin errors++; $display("FAIL bp1_drain_ready got %b exp 1", s_ready[1]); end
      checks++; if (m_valid[1] !== 1'b1) begin errors++; $display("FAIL bp1_drain_valid got %b exp 1", m_valid[1]); end
      tick();
      checks++; if (m_valid[1] !== 1'b0) begin errors++; $display("FAIL bp1_empty got %b exp 0", m_valid[1]); end
      checks++; if (m_data[1] !== 32'hB) begin errors++; $display("FAIL bp1_retain got %h exp b", m_data[1]); end
      m_ready = 2'b00;
   endtask

   task automatic test_backpressure_noskid();
      m_ready = 2'b00; s_valid = 2'b01; s_data[0] = 32'hA;
      #1;
      checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL bp0_ready_a got %b exp 1", s_ready[0]); end
      tick();
      s_data[0] = 32'hB;
      #1;
      checks++; if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL bp0_stall_ready got %b exp 0", s_ready[0]); end
      checks++; if (m_data[0] !== 32'hA) begin errors++; $display("FAIL bp0_stall_data got %h exp a", m_data[0]); end
      tick();
      checks++; if (m_data[0] !== 32'hA || m_valid[0] !== 1'b1) begin errors++; $display("FAIL bp0_hold got %h/%b exp a/1", m_data[0], m_valid[0]); end
      m_ready = 2'b01;
      #1;
      checks++; if (s_ready[0] !== 1'b1) begin errors++; $display("FAIL bp0_comb_ready got %b exp 1", s_ready[0]); end
      tick();
      checks++; if (m_data[0] !== 32'hB || m_valid[0] !== 1'b1) begin errors++; $display("FAIL bp0_next got %h/%b exp b/1", m_data[0], m_valid[0]); end
      s_valid = 2'b00;
      tick();
      checks++; if (m_valid[0] !== 1'b0) begin errors++; $display("FAIL bp0_empty got %b exp 0", m_valid[0]); end
      m_ready = 2'b00;
   endtask

   task automatic test_flush();
      m_ready = 2'b00; s_valid = 2'b11; s_data[0] = 32'h77; s_data[1] = 32'hA;
      tick();
      s_valid = 2'b10; s_data[1] = 32'hB;
      tick();
      s_valid = 2'b00;
      #1;
      checks++; if (s_ready[1] !== 1'b0 || m_valid !== 2'b11) begin errors++; $display("FAIL flush_pre got %b/%b exp 0/11", s_ready[1], m_valid); end
      flush = 1'b1; s_valid = 2'b11; s_data[0] = 32'hC; s_data[1] = 32'hC; m_ready = 2'b11;
      tick();
      flush = 1'b0; s_valid = 2'b00;
      #1;
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL flush_m_valid got %b exp 00", m_valid); end
      checks++; if (s_ready !== 2'b11) begin errors++; $display("FAIL flush_s_ready got %b exp 11", s_ready); end
      checks++; if (m_data[1] !== RST1) begin errors++; $display("FAIL flush_m_data1 got %h exp %h", m_data[1], RST1); end
      checks++; if (m_data[0] !== RST0) begin errors++; $display("FAIL flush_m_data0 got %h exp %h", m_data[0], RST0); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL flush_leak cyc=%0d got %b exp 00", i, m_valid); end
      end
      m_ready = 2'b00;
   endtask

   task automatic test_rst_flush();
      m_ready = 2'b00; s_valid = 2'b11; s_data[0] = 32'h11; s_data[1] = 32'h22;
      tick();
      rst = 1'b1; flush = 1'b1; m_ready = 2'b11; s_data[0] = 32'hD; s_data[1] = 32'hD;
      #1;
      checks++; if (s_ready !== 2'b00) begin errors++; $display("FAIL rstfl_s_ready got %b exp 00", s_ready); end
      tick();
      rst = 1'b0; flush = 1'b0; s_valid = 2'b00;
      #1;
      checks++; if (m_valid !== 2'b00 || s_ready !== 2'b11) begin errors++; $display("FAIL rstfl_state got %b/%b exp 00/11", m_valid, s_ready); end
      checks++; if (m_data[0] !== RST0 || m_data[1] !== RST1) begin errors++; $display("FAIL rstfl_data got %h/%h exp %h/%h", m_data[0], m_data[1], RST0, RST1); end
      tick();
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL rstfl_leak got %b exp 00", m_valid); end
      m_ready = 2'b00;
   endtask

   task automatic test_random();
      logic [31:0] sb [2][2];
      int          head [2];
      int          cnt [2];
      logic        hold_in [2];
      logic        stall [2];
      logic [31:0] held [2];
      for (int k = 0; k < 2; k++) begin
         head[k] = 0; cnt[k] = 0; hold_in[k] = 1'b0; stall[k] = 1'b0; held[k] = '0;
      end
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!hold_in[k]) begin
               s_valid[k] = ($urandom_range(0, 3) != 0);
               s_data[k]  = $urandom;
            end
            m_ready[k] = ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            if (stall[k]) begin
               checks++;
               if (m_valid[k] !== 1'b1 || m_data[k] !== held[k]) begin
                  errors++; $display("FAIL rand_stable k=%0d cyc=%0d got %h/%b exp %h/1", k, c, m_data[k], m_valid[k], held[k]);
               end
            end
            checks++;
            if (m_valid[k] !== (cnt[k] != 0)) begin
               errors++; $display("FAIL rand_valid k=%0d cyc=%0d got %b exp %b", k, c, m_valid[k], (cnt[k] != 0));
            end
            if (m_valid[k] && m_ready[k] && cnt[k] > 0) begin
               checks++;
               if (m_data[k] !== sb[k][head[k]]) begin
                  errors++; $display("FAIL rand_data k=%0d cyc=%0d got %h exp %h", k, c, m_data[k], sb[k][head[k]]);
               end
               head[k] = (head[k] + 1) % 2;
               cnt[k]--;
            end
            if (s_valid[k] && s_ready[k]) begin
               if (cnt[k] < 2) begin
                  sb[k][(head[k] + cnt[k]) % 2] = s_data[k];
                  cnt[k]++;
               end else begin
                  checks++; errors++;
                  $display("FAIL rand_overrun k=%0d cyc=%0d got accept exp refuse", k, c);
               end
            end
            hold_in[k] = s_valid[k] && !s_ready[k];
            stall[k]   = m_valid[k] && !m_ready[k];
            held[k]    = m_data[k];
         end
         tick();
      end
      s_valid = 2'b00; m_ready = 2'b11;
      tick(); tick(); tick();
      checks++; if (m_valid !== 2'b00) begin errors++; $display("FAIL rand_drain got %b exp 00", m_valid); end
      m_ready = 2'b00;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure_skid();
      test_backpressure_noskid();
      test_flush();
      test_rst_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
